// File: rtl/alu_wb_pkg.sv
// Shared constants and types for the ALU result write-back stage.
package alu_wb_pkg;

  localparam int LANES   = 16;
  localparam int WIDTH   = 32;
  localparam int RADDR_W = 2;

  localparam int HALF_W = LANES * WIDTH;
  localparam int RES_W  = 2 * HALF_W;
  localparam int CC_W   = 2 * LANES;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WR_LO = 2'd1,
    WR_HI = 2'd2
  } state_t;

  localparam logic [1:0] CC_ZERO = 2'b00;
  localparam logic [1:0] CC_NEG  = 2'b01;
  localparam logic [1:0] CC_POS  = 2'b10;
  localparam logic [1:0] CC_OVF  = 2'b11;

endpackage

// File: rtl/cc_overflow_detect.sv
// Flags when any lane's packed condition code reports a result wider than 32 bits.
module cc_overflow_detect
  import alu_wb_pkg::*;
(
  input  logic [CC_W-1:0] cc,
  output logic            any_ovf
);

  always_comb begin
    any_ovf = 1'b0;
    for (int i = 0; i < LANES; i++) begin
      if (cc[2*i +: 2] == CC_OVF) any_ovf = 1'b1;
    end
  end

endmodule

// File: rtl/alu_writeback.sv
// Retires one double-width ALU result into the 512-bit register-file write port.
// Optional OVERFLOW_TRAP_EN adds a sticky lane-overflow flag with a clear input.
module alu_writeback
  import alu_wb_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [RES_W-1:0]   in_result,
  input  logic [CC_W-1:0]    in_cc,
  input  logic               in_wide,
  input  logic [RADDR_W-1:0] in_dst_lo,
  input  logic [RADDR_W-1:0] in_dst_hi,
  output logic               rf_we,
  output logic [RADDR_W-1:0] rf_waddr,
  output logic [HALF_W-1:0]  rf_wdata,
  output logic               done,
`ifdef OVERFLOW_TRAP_EN
  output logic               ovf_sticky,
  input  logic               ovf_clr,
`endif
  output logic [CC_W-1:0]    cc_out
);

  state_t               state, state_next;
  logic [RES_W-1:0]     result_q;
  logic [CC_W-1:0]      cc_q;
  logic                 wide_q;
  logic [RADDR_W-1:0]   dst_lo_q, dst_hi_q;
  logic                 final_wr;
  logic                 accept;

  // The last write of an op is also the cycle a new op may be accepted.
  assign final_wr = (state == WR_HI) || ((state == WR_LO) && !wide_q);
  assign in_ready = (state == IDLE) || final_wr;
  assign accept   = in_valid && in_ready;

  // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // NOTE: the wide hold registers need no reset; outputs are gated by state, which is reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      result_q <= in_result;
      cc_q     <= in_cc;
      wide_q   <= in_wide;
      dst_lo_q <= in_dst_lo;
      dst_hi_q <= in_dst_hi;
    end
  end

  always_ff @(posedge clk) begin
    if (rst)           cc_out <= '0;
    else if (final_wr) cc_out <= cc_q;
  end

  // NOTE: every output of this block gets a default first so no latch is inferred.
  always_comb begin
    state_next = state;
    rf_we      = 1'b0;
    rf_waddr   = '0;
    rf_wdata   = '0;
    done       = final_wr;
    case (state)
      IDLE: begin
        if (accept) state_next = WR_LO;
      end
      WR_LO: begin
        rf_we    = 1'b1;
        rf_waddr = dst_lo_q;
        rf_wdata = result_q[HALF_W-1:0];
        if (wide_q)      state_next = WR_HI;
        else if (accept) state_next = WR_LO;
        else             state_next = IDLE;
      end
      WR_HI: begin
        rf_we      = 1'b1;
        rf_waddr   = dst_hi_q;
        rf_wdata   = result_q[RES_W-1:HALF_W];
        state_next = accept ? WR_LO : IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

`ifdef OVERFLOW_TRAP_EN
  logic any_ovf;

  cc_overflow_detect u_cc_overflow_detect (
    .cc      (cc_q),
    .any_ovf (any_ovf)
  );

  // Setting on a completing overflow op takes priority over a concurrent clear.
  always_ff @(posedge clk) begin
    if (rst)                       ovf_sticky <= 1'b0;
    else if (final_wr && any_ovf)  ovf_sticky <= 1'b1;
    else if (ovf_clr)              ovf_sticky <= 1'b0;
  end
`endif

endmodule

// File: tb/tb_alu_writeback.sv
// Scoreboard bench for alu_writeback: accepted ops queue their expected writes,
// a negedge monitor pops and compares each register-file write, cc_out and ready.
module tb_alu_writeback;
  import alu_wb_pkg::*;

  logic               clk;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [RES_W-1:0]   in_result;
  logic [CC_W-1:0]    in_cc;
  logic               in_wide;
  logic [RADDR_W-1:0] in_dst_lo;
  logic [RADDR_W-1:0] in_dst_hi;
  logic               rf_we;
  logic [RADDR_W-1:0] rf_waddr;
  logic [HALF_W-1:0]  rf_wdata;
  logic               done;
  logic [CC_W-1:0]    cc_out;
`ifdef OVERFLOW_TRAP_EN
  logic               ovf_sticky;
  logic               ovf_clr;
`endif

  alu_writeback dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_result (in_result),
    .in_cc     (in_cc),
    .in_wide   (in_wide),
    .in_dst_lo (in_dst_lo),
    .in_dst_hi (in_dst_hi),
    .rf_we     (rf_we),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .done      (done),
`ifdef OVERFLOW_TRAP_EN
    .ovf_sticky(ovf_sticky),
    .ovf_clr   (ovf_clr),
`endif
    .cc_out    (cc_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct packed {
    logic [RADDR_W-1:0] addr;
    logic [HALF_W-1:0]  data;
    logic               last;
    logic [CC_W-1:0]    cc;
  } wr_t;

  wr_t             exp_q[$];
  wr_t             head;
  int              n_cmp  = 0;
  int              n_fail = 0;
  bit              armed  = 1'b0;
  bit              cc_upd;
  logic [CC_W-1:0] model_cc;
`ifdef OVERFLOW_TRAP_EN
  bit              model_ovf;
`endif

  task automatic check(input string name, input logic [HALF_W-1:0] act, input logic [HALF_W-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit any_lane_ovf(input logic [CC_W-1:0] cc);
    for (int i = 0; i < LANES; i++)
      if (cc[2*i +: 2] == CC_OVF) return 1'b1;
    return 1'b0;
  endfunction

  // Monitor and reference model, evaluated away from the active edge.
  always @(negedge clk) begin
    cc_upd = 1'b0;
    if (armed) begin
      check("cc_out", HALF_W'(cc_out), HALF_W'(model_cc));
`ifdef OVERFLOW_TRAP_EN
      check("ovf_sticky", HALF_W'(ovf_sticky), HALF_W'(model_ovf));
`endif
      if (exp_q.size() > 0) begin
        head = exp_q.pop_front();
        check("rf_we", HALF_W'(rf_we), HALF_W'(1'b1));
        check("rf_waddr", HALF_W'(rf_waddr), HALF_W'(head.addr));
        check("rf_wdata", rf_wdata, head.data);
        check("done", HALF_W'(done), HALF_W'(head.last));
        check("in_ready_busy", HALF_W'(in_ready), HALF_W'(head.last));
        cc_upd = head.last;
      end else begin
        check("idle_rf_we", HALF_W'(rf_we), HALF_W'(1'b0));
        check("idle_rf_waddr", HALF_W'(rf_waddr), HALF_W'(0));
        check("idle_rf_wdata", rf_wdata, HALF_W'(0));
        check("idle_done", HALF_W'(done), HALF_W'(1'b0));
        check("idle_in_ready", HALF_W'(in_ready), HALF_W'(1'b1));
      end
    end
    if (rst) begin
      exp_q.delete();
      model_cc = '0;
`ifdef OVERFLOW_TRAP_EN
      model_ovf = 1'b0;
`endif
      armed = 1'b1;
    end else if (armed) begin
`ifdef OVERFLOW_TRAP_EN
      if (cc_upd && any_lane_ovf(head.cc)) model_ovf = 1'b1;
      else if (ovf_clr)                    model_ovf = 1'b0;
`endif
      if (cc_upd) model_cc = head.cc;
      if (in_valid && in_ready) begin
        exp_q.push_back('{addr: in_dst_lo, data: in_result[HALF_W-1:0], last: !in_wide, cc: in_cc});
        if (in_wide)
          exp_q.push_back('{addr: in_dst_hi, data: in_result[RES_W-1:HALF_W], last: 1'b1, cc: in_cc});
      end
    end
  end

  // Presents one op and holds it until the handshake edge; returns at edge+1.
  task automatic send(input logic wide, input logic [RADDR_W-1:0] lo, input logic [RADDR_W-1:0] hi,
                      input logic [RES_W-1:0] res, input logic [CC_W-1:0] cc);
    bit seen = 1'b0;
    in_valid  = 1'b1;
    in_wide   = wide;
    in_dst_lo = lo;
    in_dst_hi = hi;
    in_result = res;
    in_cc     = cc;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (in_ready) begin
        seen = 1'b1;
        break;
      end
    end
    check("accept_timeout", HALF_W'(seen), HALF_W'(1'b1));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  function automatic logic [RES_W-1:0] rand_result();
    logic [RES_W-1:0] r;
    for (int i = 0; i < 2 * LANES; i++) r[32*i +: 32] = $urandom();
    return r;
  endfunction

  logic [RES_W-1:0] res;

  initial begin
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_wide   = 1'b0;
    in_dst_lo = '0;
    in_dst_hi = '0;
    in_result = '0;
    in_cc     = '0;
`ifdef OVERFLOW_TRAP_EN
    ovf_clr   = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    idle(2);

    // Narrow op: lane0 low word 5, positive cc on lane 0.
    res = '0;
    res[31:0] = 32'd5;
    send(1'b0, 2'd1, 2'd0, res, {30'd0, CC_POS});
    idle(2);

    // Wide op: lane3 64-bit result 1<<32 with overflow cc on lane 3.
    res = '0;
    res[32*3 +: 32]          = 32'd0;
    res[HALF_W + 32*3 +: 32] = 32'd1;
    send(1'b1, 2'd0, 2'd2, res, 32'h0000_00C0);
    idle(3);

    // Four narrow ops back-to-back, no bubbles.
    for (int i = 0; i < 4; i++) send(1'b0, RADDR_W'(i), 2'd0, rand_result(), $urandom());
    idle(2);

    // Wide op writing both halves to the same register.
    send(1'b1, 2'd3, 2'd3, rand_result(), {CC_NEG, 28'd0, CC_ZERO});
    idle(3);

    // Reset during the low-half write of a wide op abandons the high write.
    send(1'b1, 2'd1, 2'd2, rand_result(), $urandom());
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(2);

`ifdef OVERFLOW_TRAP_EN
    // Lane 7 overflow sets the flag; a clear during the next overflow op's done loses.
    res = rand_result();
    send(1'b0, 2'd2, 2'd0, res, 32'h0000_C000);
    idle(2);
    send(1'b0, 2'd1, 2'd0, res, 32'h0000_C000);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    idle(1);
    ovf_clr = 1'b1;
    idle(1);
    ovf_clr = 1'b0;
    idle(2);
`endif

    // Random mix of narrow/wide ops with random gaps.
    for (int n = 0; n < 300; n++) begin
`ifdef OVERFLOW_TRAP_EN
      ovf_clr = ($urandom_range(0, 3) == 0);
`endif
      send(1'($urandom_range(0, 1)), RADDR_W'($urandom()), RADDR_W'($urandom()),
           rand_result(), $urandom());
      if ($urandom_range(0, 2) != 0) idle($urandom_range(0, 2));
    end
`ifdef OVERFLOW_TRAP_EN
    ovf_clr = 1'b0;
`endif
    idle(5);
    check("drain", HALF_W'(exp_q.size()), HALF_W'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
